// File: rtl/seq_detect_ctrl_if.sv
// Byte-stream handshake between a byte-wide producer and seq_detect_ctrl.
//   byte_valid  producer has a byte on byte_data
//   byte_data   byte to serialise, MSB first
//   byte_ready  controller accepts the byte on this cycle
// Modports: master = producer side, slave = controller side.
interface seq_detect_ctrl_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detection controller.
// Bytes arriving over the byte handshake are shifted MSB-first, one bit per
// clock, into a history register. Each new bit is checked against a
// 1..MAX_LEN-bit pattern (overlapping occurrences count, across byte
// boundaries). Every occurrence gives a one-cycle match pulse and bumps a
// saturating counter.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   cfg_we/cfg_pattern/cfg_len  configuration write (IDLE only), len clamped
//   start, stop         arm (IDLE only) / abort to IDLE (highest priority)
//   clr_count           synchronous clear of match_count
//   bus                 byte handshake (slave side)
//   match               one-cycle pulse per detected occurrence
//   match_count         saturating occurrence count
//   busy                high while ARMED or SHIFT
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               start,
  input  logic               stop,
  input  logic               clr_count,
  seq_detect_ctrl_if.slave   bus,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy
);

  localparam int              HC_W    = $clog2(MAX_LEN + 1);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(MAX_LEN);
  localparam logic [3:0]      LEN_MAX = 4'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [MAX_LEN-1:0] pattern;
  logic [3:0]         len;
  logic [MAX_LEN-1:0] hist, hist_nxt, len_mask;
  logic [HC_W-1:0]    hist_cnt, hist_cnt_nxt;
  logic [7:0]         shift_buf;
  logic [2:0]         bit_idx;
  logic               do_cfg, do_load, do_shift, do_flush, hit;

  // Length 0 means a single bit; anything beyond the history width is capped.
  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l == 4'd0)   return 4'd1;
    if (l > LEN_MAX) return LEN_MAX;
    return l;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  // byte_ready is decoded from state only, never from byte_valid.
  assign bus.byte_ready = (state == ARMED) || (state == SHIFT && bit_idx == 3'd0);
  assign busy           = (state != IDLE);

  always_comb begin
    state_d  = state;
    do_cfg   = 1'b0;
    do_load  = 1'b0;
    do_shift = 1'b0;
    do_flush = 1'b0;
    case (state)
      IDLE: begin
        do_cfg = cfg_we;
        if (start) begin
          state_d  = ARMED;
          do_flush = 1'b1;
        end
      end
      ARMED: begin
        if (bus.byte_valid) begin
          do_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        // Last bit of the byte: chain straight into the next byte if offered.
        if (bit_idx == 3'd0) begin
          if (bus.byte_valid) do_load = 1'b1;
          else                state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort drops the in-flight byte and suppresses the shift on this edge.
    if (stop) begin
      state_d  = IDLE;
      do_cfg   = 1'b0;
      do_load  = 1'b0;
      do_shift = 1'b0;
      do_flush = 1'b1;
    end
  end

  // Match is judged on the history as it will be after this edge's shift.
  always_comb begin
    hist_nxt     = {hist[MAX_LEN-2:0], shift_buf[bit_idx]};
    hist_cnt_nxt = (hist_cnt == HC_MAX) ? hist_cnt : hist_cnt + HC_W'(1);
    len_mask     = ~({MAX_LEN{1'b1}} << len);
    hit          = do_shift && (int'(hist_cnt_nxt) >= int'(len)) &&
                   ((hist_nxt & len_mask) == (pattern & len_mask));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pattern     <= '0;
      len         <= 4'd1;
      hist        <= '0;
      hist_cnt    <= '0;
      bit_idx     <= 3'd0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      state <= state_d;
      if (do_cfg) begin
        pattern <= cfg_pattern;
        len     <= clamp_len(cfg_len);
      end
      if (do_load)       bit_idx <= 3'd7;
      else if (do_shift) bit_idx <= bit_idx - 3'd1;
      if (do_flush) begin
        hist     <= '0;
        hist_cnt <= '0;
      end else if (do_shift) begin
        hist     <= hist_nxt;
        hist_cnt <= hist_cnt_nxt;
      end
      match <= hit;
      // A clear coinciding with a match leaves that match counted.
      if (clr_count)  match_count <= hit ? CNT_W'(1) : '0;
      else if (hit)   match_count <= sat_inc(match_count);
    end
  end

  // The byte being serialised needs no reset: it is only read after a load.
  always_ff @(posedge clk) begin
    if (do_load) shift_buf <= bus.byte_data;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial-pattern detection controller. It accepts bytes over a valid/ready handshake and serialises them MSB-first into an internal shift history one bit per clock. It compares the history against a configured pattern of 1..MAX_LEN bits, with overlapping detection, and flags and counts every occurrence. It sits between a byte-wide producer and the bit-serial pattern-detection logic, and owns arming, configuration, bit sequencing and match accounting.

## Interface

Parameters:
- MAX_LEN, 8, maximum pattern length in bits; also the history width.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset. Asserting low clears all state immediately; release is sampled on clk.
- cfg_we  input  1  configuration write strobe; honoured only in IDLE.
- cfg_pattern  input  MAX_LEN  pattern bits; bit 0 is the most recently received bit of the match.
- cfg_len  input  4  pattern length. 0 is treated as 1; values above MAX_LEN are treated as MAX_LEN.
- start  input  1  arm the detector; honoured only in IDLE.
- stop  input  1  abort and return to IDLE; has priority over everything except reset.
- clr_count  input  1  synchronous clear of match_count.
- byte_valid  input  1  producer has a byte.
- byte_data  input  8  byte to serialise, MSB first.
- byte_ready  output  1  controller can accept a byte this cycle.
- match  output  1  one-cycle pulse per detected occurrence.
- match_count  output  CNT_W  saturating count of matches since the last clear.
- busy  output  1  high in ARMED or SHIFT.

## Operation

States:
- IDLE
  - start=1 goes to ARMED. The history and the valid-bit counter (hist_cnt) are cleared.
  - cfg_we=1 latches the pattern and the clamped length. If cfg_we and start are both high in the same cycle, the configuration is latched and the controller arms, using the new configuration.
- ARMED
  - byte_ready=1.
  - On a handshake (byte_valid & byte_ready), byte_data goes into a shift buffer, bit_idx is set to 7, and the state moves to SHIFT.
- SHIFT
  - Each cycle, buffer[bit_idx] is shifted into history bit 0 (older bits move up), hist_cnt increments and saturates at MAX_LEN, and bit_idx decrements.
  - byte_ready=1 only on the cycle with bit_idx==0. A handshake on that cycle loads the next byte and stays in SHIFT with bit_idx=7. Otherwise the state goes to ARMED.
- stop=1 in any state goes to IDLE at the next edge.
  - The partially shifted byte is discarded; history and hist_cnt are cleared.
  - match_count is held.
- cfg_we outside IDLE is ignored; the configuration does not change.

Match rule:
- Evaluated on the updated history at each shift edge: hist_cnt(updated) ≥ len AND the low len bits of the history equal the low len bits of the pattern.
- Overlapping occurrences all count. Matches span byte boundaries. History is never cleared between bytes while armed.
- On a match, match_count increments at that edge and saturates at 2^CNT_W−1.
- If clr_count and a match occur on the same edge, match_count ends at 1.

## Timing

- Reset values:
  - state IDLE
  - byte_ready 0, match 0, match_count 0, busy 0
  - pattern 0, len 1, history 0, hist_cnt 0
- Latency from handshake edge H:
  - The first bit (MSB) enters history at edge H+1.
  - Bit k (MSB = 1) enters at H+k.
  - match is registered: it is high during the cycle after the edge on which the completing bit entered.
- Throughput: with byte_valid held high, one byte every 8 cycles and no bubble.
- byte_ready is a registered/state-decoded output and does not depend on byte_valid combinationally.
- busy=1 from the edge after start until the edge after stop.
- When stop and a shift occur on the same cycle, the shift is not performed and no match is flagged.
- Reset asserted mid-SHIFT clears everything immediately (asynchronously). No match pulse is produced afterwards.

## Test plan

- Basic match: cfg pattern=0x0B, len=4; start; send 0xB0. Required: exactly one match pulse, in the cycle after edge H+4; match_count=1; byte_ready returns at H+8.
- Overlap: pattern=0x05, len=3; send 0xA8. Required: match pulses after H+3 and H+5; match_count=2.
- Cross-byte and back-to-back: pattern=0x0B, len=4; send 0x01 then 0x60 with byte_valid held high. Required: second handshake at H+8; single match after edge H+11; count=1; no idle cycle between bytes.
- Saturation and clear: CNT_W=2, pattern=0x01, len=1; send 0xFF. Required: 8 match pulses; count sticks at 3. Then pulse clr_count together with a match: count=1.
- Config guarding and clamping:
  - Write cfg_len=12 in IDLE: effective length is 8.
  - Write cfg_len=0: effective length is 1.
  - While ARMED, cfg_we with a new pattern: no effect, because the old pattern still matches.
- Abort and reset mid-byte:
  - Send 0xB0 with pattern 0x0B/len 4, and assert stop at H+2. Required: IDLE, no match, count unchanged.
  - Repeat with reset low at H+2. Required: all outputs at reset values immediately.
